// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - pipelined adder/subtractor, one carry-lookahead group per stage
// Valid/ready handshake; a downstream stall freezes every stage at once.
module add_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / BLOCK;

  // Flat sum-of-products carries: each carry is built directly from g/p terms.
  function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x,
                                                input logic [BLOCK-1:0] y,
                                                input logic             ci);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  b_q  [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;
  logic              rdy_q;

  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];
  logic [BLOCK:0]    grp  [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_nx;
  logic [STAGES-1:0] v_in;
  logic              ovf_nx;
  logic              stall;

  assign stall     = v_q[STAGES-1] && !out_ready;
  assign in_ready  = rdy_q && !stall;
  assign out_valid = v_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  always_comb begin
    // Subtraction is folded in up front: b is inverted and the +1 rides on carry-in.
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in    = '0;
    v_in    = '0;
    c_in[0] = sub ? 1'b1 : cin;
    s_in[0] = '0;
    v_in[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
    c_nx = '0;
    for (int k = 0; k < STAGES; k++) begin
      grp[k]  = cla_group(a_in[k][k*BLOCK +: BLOCK], b_in[k][k*BLOCK +: BLOCK], c_in[k]);
      s_nx[k] = s_in[k];
      s_nx[k][k*BLOCK +: BLOCK] = grp[k][BLOCK-1:0];
      c_nx[k] = grp[k][BLOCK];
    end
    ovf_nx = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
             (s_nx[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (!stall) begin
        for (int k = 0; k < STAGES; k++) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nx[k];
        end
        c_q   <= c_nx;
        v_q   <= v_in;
        ovf_q <= ovf_nx;
      end
    end
  end
endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - self-checking bench for add_sub_pipe (16-bit pipe and 4-bit single stage)
module tb_add_sub_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] s;

  logic        in_valid4, out_ready4, cin4, sub4;
  logic [3:0]  a4, b4;
  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [3:0]  s4;

  add_sub_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf));

  add_sub_pipe #(.WIDTH(4), .BLOCK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .s(s4), .cout(cout4), .ovf(ovf4));

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        cout, ovf;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_acc   = 0;
  int n_stall = 0;
  int n_out4  = 0;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain unbounded arithmetic, overflow as signed range violation.
  function automatic res_t model(input int w, input longint x, input longint y,
                                 input bit ci, input bit sb);
    longint m, half, sum, sx, sy, ss;
    res_t r;
    m    = longint'(1) << w;
    half = m / 2;
    sx   = (x >= half) ? x - m : x;
    sy   = (y >= half) ? y - m : y;
    if (sb) begin
      sum = x - y + m;
      ss  = sx - sy;
    end else begin
      sum = x + y + longint'(ci);
      ss  = sx + sy + longint'(ci);
    end
    r.s    = 16'(sum % m);
    r.cout = (sum >= m);
    r.ovf  = (ss >= half) || (ss < -half);
    return r;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  logic        live = 1'b0;
  logic        hold = 1'b0;
  logic [17:0] hold_val;
  always @(posedge clk) live = rst_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold = 1'b0;
      live = 1'b0;
    end else if (live) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (hold) begin
        chk("hold out_valid", out_valid, 1);
        chk("hold result", {s, cout, ovf}, hold_val);
      end
      hold     = out_valid && !out_ready;
      hold_val = {s, cout, ovf};
      if (out_valid && !out_ready) n_stall++;
      if (out_valid && out_ready) begin
        chk("result expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          res_t e;
          e = exp_q.pop_front();
          chk("sb s", s, e.s);
          chk("sb cout", cout, e.cout);
          chk("sb ovf", ovf, e.ovf);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(16, a, b, cin, sub));
        n_acc++;
      end
    end
  end

  logic prev4 = 1'b0;
  res_t pe4;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev4 = 1'b0;
    end else begin
      chk("w4 latency", out_valid4, prev4);
      if (out_valid4 && prev4) begin
        chk("w4 s", s4, pe4.s[3:0]);
        chk("w4 cout", cout4, pe4.cout);
        chk("w4 ovf", ovf4, pe4.ovf);
        n_out4++;
      end
      prev4 = in_valid4 && in_ready4;
      if (prev4) pe4 = model(4, a4, b4, cin4, sub4);
    end
  end

  task automatic put(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic xs);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
  endtask

  // Caller has just driven a transaction; this edge accepts it.
  task automatic measure(input string nm, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat <= 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, 4);
    chk({nm, " s"}, s, es);
    chk({nm, " cout"}, cout, ec);
    chk({nm, " ovf"}, ovf, eo);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    chk("drain empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];
  logic pat[4];

  initial begin
    int n0, a0, st0, acc, tmo;
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset s", s, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);
    chk("reset w4 out_valid", out_valid4, 0);
    chk("reset w4 s", s4, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready after release", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      put(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      measure($sformatf("vec%0d", i), tbl[i].s, tbl[i].cout, tbl[i].ovf);
    end
    drain();

    // Back-to-back stream against a 1,0,0,1 out_ready pattern.
    n0 = n_out; st0 = n_stall;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          put(pick(), pick(), 1'($urandom), 1'($urandom));
          acc = 0; tmo = 0;
          while (!acc && tmo < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            tmo++;
          end
          chk("bp accept bound", acc, 1);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = pat[c % 4];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp result count", n_out - n0, 8);
    chk("bp stalls seen", n_stall > st0, 1);

    n0 = n_out; a0 = n_acc;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    chk("rand in/out count", n_out - n0, n_acc - a0);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      put(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset in_ready", in_ready, 0);
    chk("midreset s", s, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post-reset out_valid", out_valid, 0);
      if (i == 1) chk("post-reset in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    put(16'h1234, 16'h4321, 1'b1, 1'b0);
    measure("post-reset txn", 16'h5556, 1'b0, 1'b0);
    drain();

    // Exhaustive 4-bit sweep at full rate.
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk); #1;
      in_valid4 = 1'b1;
      {sub4, cin4, a4, b4} = 10'(i);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("w4 result count", n_out4, 1024);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits; legal values are multiples of BLOCK, from 4 to 64.
REQ-002 The block SHALL have parameter BLOCK, default 4, giving the carry-lookahead group width per pipeline stage.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the operands are presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each, the operands.
REQ-008 The block SHALL have port cin, input, 1 bit, the carry-in; it applies in add mode only.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-012 The block SHALL have port s, output, WIDTH bits, the sum or difference.
REQ-013 The block SHALL have port cout, output, 1 bit, the carry out of the MSB.
REQ-014 The block SHALL have port ovf, output, 1 bit, the two's-complement signed overflow flag.

Function
REQ-015 The block SHALL form a pipeline of STAGES = WIDTH/BLOCK stages; stage k computes bits [k*BLOCK +: BLOCK] using BLOCK-bit carry lookahead (generate/propagate, no ripple within a group).
REQ-016 Stage k SHALL register its group sum and group carry-out; it SHALL also carry the not-yet-added upper operand slices and a valid bit forward.
REQ-017 In add mode (sub=0), the result SHALL be {cout,s} = a + b + cin, computed modulo 2^(WIDTH+1).
REQ-018 In subtract mode (sub=1), the result SHALL be a + ~b + 1; cin is ignored; cout=1 means no borrow.
REQ-019 ovf SHALL be 1 iff the sign of the operand a equals the sign of the effective b operand (b, or ~b when sub=1) and the sign of s differs from that sign.
REQ-020 The handshake SHALL be as follows: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-021 stall SHALL be defined as out_valid && !out_ready; when stall is asserted, every pipeline register SHALL hold and in_ready SHALL be 0.
REQ-022 When stall is not asserted, in_ready SHALL be 1, including when the pipeline is full, so that one result is accepted per cycle at full throughput.
REQ-023 Latency SHALL be STAGES cycles: a result accepted at edge N is presented with out_valid=1 after edge N+STAGES-1, provided no stall occurs; each stall cycle adds one cycle.
REQ-024 Bubbles SHALL propagate: a cycle with in_valid=0 and no stall enters a stage with valid=0, and no spurious out_valid is produced.
REQ-025 Results SHALL leave the block in acceptance order; no transaction is dropped or duplicated under any out_ready pattern.
REQ-026 Outputs s, cout and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 When out_valid=0, the values on s, cout and ovf are don't-care, but they SHALL NOT be X after reset.

Reset
REQ-028 While rst_n=0, all stage valid bits, out_valid, s, cout and ovf SHALL be 0; in_ready SHALL be 0 during reset and 1 on the first clock after release.
REQ-029 Asserting reset mid-operation SHALL discard all in-flight transactions immediately (asynchronously), and no stale result SHALL appear after release.

Verification (WIDTH=16, BLOCK=4, latency 4)
REQ-030 Add: a=16'h00FF, b=16'h0001, cin=0, sub=0 -> after 4 cycles s=16'h0100, cout=0, ovf=0.
REQ-031 Carry chain and overflow: a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, cout=1, ovf=0; a=16'h7FFF, b=16'h0001, cin=0 -> s=16'h8000, ovf=1.
REQ-032 Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 -> s=16'hFFFE, cout=0, ovf=0; a=16'h8000, b=16'h0001, sub=1 -> s=16'h7FFF, ovf=1.
REQ-033 Backpressure: feed 8 back-to-back transactions while out_ready toggles 1,0,0,1,... -> in_ready=0 exactly during stall cycles, and all 8 results arrive in order and correct.
REQ-034 Reset mid-flight: accept 3 transactions, pull rst_n low for 1 cycle, then release -> out_valid stays 0 until a new input has traversed 4 stages.
REQ-035 Exhaustive sweep with WIDTH=4, BLOCK=4: all a, b, cin and sub combinations (1024 in total) streamed at full rate -> every result matches the reference equation, with latency 1.
